// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache.
// Dcache two-word blocks stay atomic; a counter bounds icache starvation.

package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IGNT = 2'd1;
  localparam logic [1:0] DGNT = 2'd2;

  logic [1:0]    arb_state;
  logic [1:0]    arb_next;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_next;
  logic          dreq;
  logic          starved;
  logic          acc;

  assign iload   = ramload;
  assign dload   = ramload;
  assign dreq    = dREN | dWEN;
  assign starved = starve_cnt == CW'(STARVE_MAX);
  assign acc     = ramstate == ACCESS;

  // Arbitration, RAM strobes and wait handshakes
  always_comb begin
    arb_next = arb_state;
    cnt_next = starve_cnt;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (arb_state)
      IDLE: begin
        if (dreq && !(iREN && starved)) begin
          arb_next = DGNT;
          if (!iREN)
            cnt_next = '0;
          else if (!starved)
            cnt_next = starve_cnt + CW'(1);
        end else if (iREN) begin
          arb_next = IGNT;
          cnt_next = '0;
        end else begin
          cnt_next = '0;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          arb_next = IDLE;
        end else if (acc) begin
          iwait    = 1'b0;
          arb_next = IDLE;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          arb_next = IDLE;
        end else if (acc) begin
          dwait    = 1'b0;
          arb_next = daddr[2] ? IDLE : DGNT;
        end
      end
      default: arb_next = IDLE;
    endcase
  end

  // Grant state and starvation counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      arb_state  <= IDLE;
      starve_cnt <= '0;
    end else begin
      arb_state  <= arb_next;
      starve_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grants, blocks,
// starvation bound and asynchronous reset.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h10;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = 32'h12345678; ramstate = FREE;

    // reset held with iREN pending
    step(); step(); #2;
    chk("rst_ren", {31'd0, ramREN}, 32'd0);
    chk("rst_wen", {31'd0, ramWEN}, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);
    step(); nRST = 1'b1; #2;
    chk("rel_idle", {31'd0, ramREN}, 32'd0);
    step(); #2;
    chk("rel_ren", {31'd0, ramREN}, 32'd1);
    chk("rel_addr", ramaddr, 32'h10);
    ramstate = ACCESS; #1;
    chk("rel_iwait", {31'd0, iwait}, 32'd0);
    step(); iREN = 1'b0; ramstate = FREE;

    // icache read with two BUSY cycles
    step(); iREN = 1'b1; iaddr = 32'h40; #2;
    chk("ird_idle_wait", {31'd0, iwait}, 32'd1);
    chk("ird_idle_ren", {31'd0, ramREN}, 32'd0);
    step(); ramstate = BUSY; #2;
    chk("ird_ren", {31'd0, ramREN}, 32'd1);
    chk("ird_addr", ramaddr, 32'h40);
    chk("ird_busy1", {31'd0, iwait}, 32'd1);
    step(); #2;
    chk("ird_busy2", {31'd0, iwait}, 32'd1);
    step(); ramstate = ACCESS; ramload = 32'hA5A5_0040; #2;
    chk("ird_acc", {31'd0, iwait}, 32'd0);
    chk("ird_load", iload, 32'hA5A5_0040);
    chk("ird_dwait", {31'd0, dwait}, 32'd1);
    step(); #2;
    chk("ird_bubble_ren", {31'd0, ramREN}, 32'd0);
    chk("ird_bubble_wait", {31'd0, iwait}, 32'd1);
    iREN = 1'b0; ramstate = FREE;

    // dcache fill while icache waits
    step(); iREN = 1'b1; dREN = 1'b1; daddr = 32'h100;
    step(); ramstate = ACCESS; ramload = 32'h1111_0100; #2;
    chk("fill0_ren", {31'd0, ramREN}, 32'd1);
    chk("fill0_addr", ramaddr, 32'h100);
    chk("fill0_dwait", {31'd0, dwait}, 32'd0);
    chk("fill0_dload", dload, 32'h1111_0100);
    chk("fill0_iwait", {31'd0, iwait}, 32'd1);
    step(); daddr = 32'h104; #2;
    chk("fill1_ren", {31'd0, ramREN}, 32'd1);
    chk("fill1_addr", ramaddr, 32'h104);
    chk("fill1_dwait", {31'd0, dwait}, 32'd0);
    chk("fill1_iwait", {31'd0, iwait}, 32'd1);
    step(); dREN = 1'b0; ramstate = FREE; #2;
    chk("fill_end_ren", {31'd0, ramREN}, 32'd0);
    chk("fill_cnt", 32'(dut.starve_cnt), 32'd1);
    step(); ramstate = ACCESS; #2;
    chk("fill_ig_iwait", {31'd0, iwait}, 32'd0);
    chk("fill_ig_cnt", 32'(dut.starve_cnt), 32'd0);
    step(); iREN = 1'b0; ramstate = FREE;

    // dirty write-back
    step(); dWEN = 1'b1; daddr = 32'h208; dstore = 32'hDEADBEEF;
    step(); ramstate = ACCESS; #2;
    chk("wb0_wen", {31'd0, ramWEN}, 32'd1);
    chk("wb0_ren", {31'd0, ramREN}, 32'd0);
    chk("wb0_addr", ramaddr, 32'h208);
    chk("wb0_data", ramstore, 32'hDEADBEEF);
    chk("wb0_dwait", {31'd0, dwait}, 32'd0);
    step(); daddr = 32'h20C; dstore = 32'hCAFEF00D; #2;
    chk("wb1_wen", {31'd0, ramWEN}, 32'd1);
    chk("wb1_addr", ramaddr, 32'h20C);
    chk("wb1_data", ramstore, 32'hCAFEF00D);
    chk("wb1_dwait", {31'd0, dwait}, 32'd0);
    step(); dWEN = 1'b0; ramstate = FREE; #2;
    chk("wb_end_wen", {31'd0, ramWEN}, 32'd0);
    chk("wb_end_dwait", {31'd0, dwait}, 32'd1);

    // starvation bound: 4 dcache grants then 1 icache grant
    step();
    iREN = 1'b1; iaddr = 32'h80;
    dREN = 1'b1; daddr = 32'h304; ramstate = ACCESS;
    for (int g = 0; g < 10; g++) begin
      #2;
      chk($sformatf("stv%0d_idle", g), {31'd0, ramREN}, 32'd0);
      step(); #2;
      if (g % 5 == 4) begin
        chk($sformatf("stv%0d_iw", g), {31'd0, iwait}, 32'd0);
        chk($sformatf("stv%0d_dw", g), {31'd0, dwait}, 32'd1);
        chk($sformatf("stv%0d_a", g), ramaddr, 32'h80);
      end else begin
        chk($sformatf("stv%0d_iw", g), {31'd0, iwait}, 32'd1);
        chk($sformatf("stv%0d_dw", g), {31'd0, dwait}, 32'd0);
        chk($sformatf("stv%0d_a", g), ramaddr, 32'h304);
      end
      chk($sformatf("stv%0d_cnt", g), 32'(dut.starve_cnt),
          (g % 5 == 4) ? 32'd0 : 32'(g % 5 + 1));
      step();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;

    // reset between block words
    step(); dREN = 1'b1; daddr = 32'h400;
    step(); ramstate = ACCESS; #2;
    chk("mrst_w0_dwait", {31'd0, dwait}, 32'd0);
    step(); daddr = 32'h404; ramstate = BUSY; #2;
    chk("mrst_w1_ren", {31'd0, ramREN}, 32'd1);
    nRST = 1'b0; #1;
    chk("mrst_ren", {31'd0, ramREN}, 32'd0);
    chk("mrst_dwait", {31'd0, dwait}, 32'd1);
    chk("mrst_addr", ramaddr, 32'd0);
    dREN = 1'b0; iREN = 1'b1; iaddr = 32'h500; ramstate = FREE;
    step(); nRST = 1'b1; #2;
    chk("mrst_idle", {31'd0, ramREN}, 32'd0);
    chk("mrst_cnt", 32'(dut.starve_cnt), 32'd0);
    step(); #2;
    chk("mrst_ig_ren", {31'd0, ramREN}, 32'd1);
    chk("mrst_ig_addr", ramaddr, 32'h500);
    chk("mrst_ig_dwait", {31'd0, dwait}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache of one pipelined core. It accepts word requests from both caches, grants the shared RAM port to one at a time, and forwards RAM handshakes back to the winner. Data-cache two-word block transfers (fills and dirty write-backs) are kept atomic. A starvation counter bounds how long instruction fetch can be locked out by data traffic.

## Interface
- STARVE_MAX, 4: consecutive dcache grants allowed while icache waits before icache is forced to win (≥1).
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 only in the icache grant cycle where ramstate==ACCESS.
- iload  out  32  read data to icache; equals ramload.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high (illegal, tolerated).
- daddr  in  32  dcache word address; bit 2 is the word-in-block offset.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 only in the dcache grant cycle where ramstate==ACCESS.
- dload  out  32  read data to dcache; equals ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR; ERROR is treated as BUSY.

## Operation
- State register arb_state: IDLE, IGNT, DGNT. Counter starve_cnt has width $clog2(STARVE_MAX+1).
- IDLE:
  - Drive no strobes.
  - Arbitrate on the current cycle's requests and register the result at the next edge.
  - Only icache requesting → IGNT.
  - Only dcache requesting (dREN|dWEN) → DGNT.
  - Both requesting → DGNT, unless starve_cnt==STARVE_MAX, in which case → IGNT.
  - Neither requesting → stay in IDLE.
- Counter update at the arbitration edge:
  - DGNT chosen while iREN=1 → starve_cnt+1, saturating at STARVE_MAX.
  - IGNT chosen, or iREN=0 → starve_cnt cleared to 0.
- IGNT:
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - On ACCESS: iwait=0, next state IDLE.
- DGNT:
  - ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - On ACCESS: dwait=0.
    - daddr[2]==0 (first word of block) → stay in DGNT for the second word, with no IDLE bubble.
    - daddr[2]==1 → next state IDLE.
- Granted requester drops its request while in a grant state:
  - Strobes go low combinationally in the same cycle.
  - Next state IDLE.
  - starve_cnt unchanged.
- The non-granted requester always sees wait=1, even with no request pending.
- iload and dload are permanently wired to ramload.

## Timing
- Reset state: arb_state=IDLE, starve_cnt=0.
- Output values under reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Reset is asynchronous. Asserting it mid-grant drops the strobes immediately; the transfer in progress is abandoned.
- All outputs are combinational from arb_state, the granted requester's inputs and ramstate. Only arb_state and starve_cnt are registered.
- Minimum latency, request to data:
  - Request visible in IDLE in cycle 0.
  - Grant from cycle 1.
  - wait=0 in the first cycle of the grant in which ramstate==ACCESS.
  - With a RAM returning ACCESS in the first strobe cycle, iwait=0 in cycle 1.
- Block transfer: word 0 ACCESS in cycle k, word 1 strobed in cycle k+1 with no IDLE cycle between the two words.
- Back-to-back accesses by the same cache are separated by one IDLE cycle, except inside a dcache block.
- Simultaneous events:
  - A new request arriving during another cache's grant waits; it is evaluated only in IDLE.
  - Requests arriving in the same IDLE cycle are resolved by the priority rules under Operation.

## Test plan
- Reset with iREN=1 held → ramREN=0, iwait=1, dwait=1 during reset. After release, IGNT and ramaddr=iaddr in the first cycle.
- Icache-only read of iaddr=0x40, RAM ACCESS after 2 BUSY cycles → iwait=0 for exactly one cycle, iload=ramload, then IDLE for one cycle.
- Dcache fill with daddr=0x100 then 0x104 while iREN=1 → both words served in consecutive grant cycles with no icache access between them. iwait stays 1 throughout. starve_cnt=1 afterwards.
- Dirty write-back with dWEN=1, daddr=0x208 then 0x20C, dstore=0xDEADBEEF then 0xCAFEF00D → ramWEN=1, ramstore matches each word, dwait pulses low twice.
- Starvation with STARVE_MAX=4, dcache single-word requests (daddr[2]=1) continuously, iREN held high → exactly 4 dcache grants, then 1 icache grant, then starve_cnt=0 and the pattern repeats.
- Reset asserted mid DGNT between word 0 and word 1 → strobes drop in the same cycle. After release, state is IDLE, starve_cnt=0, and a pending iREN wins if it is the only request.
